// File: rtl/t07_ext_reg_bank.sv
// t07_ext_reg_bank
// Double-buffered register bank fed by the quad-SPI receive stage.
// SPI writes land in a shadow copy. On the rising edge of chip select the
// written entries are copied into the active copy in a single clock.
// The CPU reads only the active copy, so it never observes a partial frame.
module t07_ext_reg_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 31,
  parameter int FCNT_W   = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              spi_cs_i,
  input  logic              spi_wr_i,
  input  logic [ADDR_W-1:0] spi_addr_i,
  input  logic [DATA_W-1:0] spi_data_i,
  input  logic              cpu_rd_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_rd_data_o,
  output logic              cpu_rd_ack_o,
  input  logic              frame_clear_i,
  output logic              frame_ready_o,
  output logic              overrun_o,
  output logic [FCNT_W-1:0] frame_count_o,
  output logic [31:0]       wr_mask_o
);

  // One slot per address the bus can express. Slot 0 and any slot above
  // NUM_REGS are tied to zero, so a read of them needs no range check.
  localparam int SLOTS = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic              cs_q_reg;
  logic              cs_rise;
  logic              commit;
  logic              spi_wr_ok;
  logic [SLOTS-1:0]  shadow_mask;
  logic [DATA_W-1:0] active_word [0:SLOTS-1];

  logic [0:0]        state_reg;
  logic [0:0]        state_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic [31:0]       wr_mask_reg;
  logic [FCNT_W-1:0] frame_count_reg;
  logic              frame_ready_reg;
  logic              overrun_reg;

  // A write only counts inside a frame. Address decoding happens per slot,
  // so address 0 and out-of-range addresses simply match nothing.
  assign spi_wr_ok = spi_wr_i & ~spi_cs_i;
  assign cs_rise   = spi_cs_i & ~cs_q_reg;
  // A CS pulse that carried no writes must leave every output untouched.
  assign commit    = cs_rise & (|shadow_mask);

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi >= 1 && gi <= NUM_REGS) begin : g_live
        logic [DATA_W-1:0] shadow_reg;
        logic [DATA_W-1:0] active_reg;
        logic              written_reg;
        logic              hit;

        assign hit = spi_wr_ok && (spi_addr_i == ADDR_W'(gi));

        // Shadow entry: the last write in a frame wins. The written flag is dropped at commit.
        always_ff @(posedge clk or negedge nrst) begin
          if (!nrst) begin
            shadow_reg  <= '0;
            written_reg <= 1'b0;
          end else if (hit) begin
            shadow_reg  <= spi_data_i;
            written_reg <= 1'b1;
          end else if (commit) begin
            written_reg <= 1'b0;
          end
        end

        // Active entry: updated only at commit, and only if this frame wrote it.
        always_ff @(posedge clk or negedge nrst) begin
          if (!nrst) begin
            active_reg <= '0;
          end else if (commit && written_reg) begin
            active_reg <= shadow_reg;
          end
        end

        assign shadow_mask[gi] = written_reg;
        assign active_word[gi] = active_reg;
      end else begin : g_tie
        assign shadow_mask[gi] = 1'b0;
        assign active_word[gi] = '0;
      end
    end
  endgenerate

  // Registered chip select. It resets to idle-high, so leaving reset with CS high is not seen as a rise.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cs_q_reg <= 1'b1;
    end else begin
      cs_q_reg <= spi_cs_i;
    end
  end

  // Frame status. A commit on the same edge as a clear wins, so the CPU cannot miss a frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_mask_reg     <= '0;
      frame_count_reg <= '0;
      frame_ready_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else if (commit) begin
      wr_mask_reg     <= shadow_mask;
      frame_count_reg <= frame_count_reg + FCNT_W'(1);
      frame_ready_reg <= 1'b1;
      overrun_reg     <= overrun_reg | frame_ready_reg;
    end else if (frame_clear_i) begin
      frame_ready_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end
  end

  // Read FSM next state: accept in IDLE, acknowledge for one cycle, then return to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (cpu_rd_req_i) state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Read FSM state and data capture. The capture sees pre-commit contents on a shared edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= ST_IDLE;
      rd_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && cpu_rd_req_i) begin
        rd_data_reg <= active_word[cpu_addr_i];
      end
    end
  end

  assign cpu_rd_data_o = rd_data_reg;
  assign cpu_rd_ack_o  = (state_reg == ST_ACK);
  assign frame_ready_o = frame_ready_reg;
  assign overrun_o     = overrun_reg;
  assign frame_count_o = frame_count_reg;
  assign wr_mask_o     = wr_mask_reg;

endmodule

// File: tb/tb_t07_ext_reg_bank.sv
// Testbench for t07_ext_reg_bank: directed frames, with a read scoreboard
// checked by an independent ack monitor.
module tb_t07_ext_reg_bank;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 30;
  localparam int FCNT_W   = 8;

  logic              clk;
  logic              nrst;
  logic              spi_cs_i;
  logic              spi_wr_i;
  logic [ADDR_W-1:0] spi_addr_i;
  logic [DATA_W-1:0] spi_data_i;
  logic              cpu_rd_req_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_rd_data_o;
  logic              cpu_rd_ack_o;
  logic              frame_clear_i;
  logic              frame_ready_o;
  logic              overrun_o;
  logic [FCNT_W-1:0] frame_count_o;
  logic [31:0]       wr_mask_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int ack_count    = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  t07_ext_reg_bank #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS),
    .FCNT_W  (FCNT_W)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .spi_cs_i     (spi_cs_i),
    .spi_wr_i     (spi_wr_i),
    .spi_addr_i   (spi_addr_i),
    .spi_data_i   (spi_data_i),
    .cpu_rd_req_i (cpu_rd_req_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_rd_data_o(cpu_rd_data_o),
    .cpu_rd_ack_o (cpu_rd_ack_o),
    .frame_clear_i(frame_clear_i),
    .frame_ready_o(frame_ready_o),
    .overrun_o    (overrun_o),
    .frame_count_o(frame_count_o),
    .wr_mask_o    (wr_mask_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_write(input logic [4:0] a, input logic [31:0] d);
    spi_wr_i   = 1'b1;
    spi_addr_i = a;
    spi_data_i = d;
    tick();
    spi_wr_i   = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back(d);
    exp_addr_q.push_back({27'd0, a});
  endtask

  // Single read: request is accepted on the first edge, ack is seen before the second.
  task automatic cpu_read(input logic [4:0] a, input logic [31:0] d);
    push_exp(a, d);
    cpu_addr_i   = a;
    cpu_rd_req_i = 1'b1;
    tick();
    cpu_rd_req_i = 1'b0;
    tick();
  endtask

  // Monitor: every ack pops one expected word from the scoreboard.
  always @(negedge clk) begin
    if (nrst && cpu_rd_ack_o) begin
      ack_count++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_ack: got data 0x%08h, required no ack", cpu_rd_data_o);
      end else begin
        logic [31:0] e;
        logic [31:0] ea;
        e  = exp_q.pop_front();
        ea = exp_addr_q.pop_front();
        check($sformatf("rd_addr%0d", ea), cpu_rd_data_o, e);
      end
    end
  end

  initial begin
    int acks_before;
    nrst          = 1'b0;
    spi_cs_i      = 1'b1;
    spi_wr_i      = 1'b0;
    spi_addr_i    = '0;
    spi_data_i    = '0;
    cpu_rd_req_i  = 1'b0;
    cpu_addr_i    = '0;
    frame_clear_i = 1'b0;
    tick();
    tick();

    // 1. reset state
    check("rst_wr_mask", wr_mask_o, 32'h0);
    check("rst_ready", {31'd0, frame_ready_o}, 32'h0);
    check("rst_overrun", {31'd0, overrun_o}, 32'h0);
    check("rst_count", {24'd0, frame_count_o}, 32'h0);
    check("rst_ack", {31'd0, cpu_rd_ack_o}, 32'h0);
    check("rst_rd_data", cpu_rd_data_o, 32'h0);
    nrst = 1'b1;
    tick();
    cpu_read(5'd5, 32'h0);

    // 2/3. first frame, mid-frame read, ignored addresses
    spi_cs_i = 1'b0;
    tick();
    spi_write(5'd1, 32'hDEADBEEF);
    cpu_read(5'd1, 32'h0);
    spi_write(5'd2, 32'h12345678);
    spi_write(5'd0, 32'h11111111);
    spi_write(5'd31, 32'h22222222);
    spi_cs_i = 1'b1;
    tick();
    check("f1_wr_mask", wr_mask_o, 32'h6);
    check("f1_ready", {31'd0, frame_ready_o}, 32'h1);
    check("f1_overrun", {31'd0, overrun_o}, 32'h0);
    check("f1_count", {24'd0, frame_count_o}, 32'h1);
    cpu_read(5'd1, 32'hDEADBEEF);
    check("rd_hold", cpu_rd_data_o, 32'hDEADBEEF);
    cpu_read(5'd2, 32'h12345678);
    cpu_read(5'd31, 32'h0);
    cpu_read(5'd0, 32'h0);

    // 4. second frame, read and clear on the commit edge
    spi_cs_i = 1'b0;
    tick();
    spi_write(5'd2, 32'hA5A5A5A5);
    push_exp(5'd2, 32'h12345678);
    spi_cs_i      = 1'b1;
    cpu_addr_i    = 5'd2;
    cpu_rd_req_i  = 1'b1;
    frame_clear_i = 1'b1;
    tick();
    cpu_rd_req_i  = 1'b0;
    frame_clear_i = 1'b0;
    check("f2_wr_mask", wr_mask_o, 32'h4);
    check("f2_ready", {31'd0, frame_ready_o}, 32'h1);
    check("f2_overrun", {31'd0, overrun_o}, 32'h1);
    check("f2_count", {24'd0, frame_count_o}, 32'h2);
    tick();
    cpu_read(5'd2, 32'hA5A5A5A5);
    cpu_read(5'd1, 32'hDEADBEEF);

    // flag clear, write with CS high ignored, last write wins
    frame_clear_i = 1'b1;
    tick();
    frame_clear_i = 1'b0;
    check("clr_ready", {31'd0, frame_ready_o}, 32'h0);
    check("clr_overrun", {31'd0, overrun_o}, 32'h0);
    spi_write(5'd3, 32'h00000033);
    spi_cs_i = 1'b0;
    tick();
    spi_write(5'd4, 32'h00000040);
    spi_write(5'd4, 32'h00000044);
    spi_cs_i = 1'b1;
    tick();
    check("f3_wr_mask", wr_mask_o, 32'h10);
    check("f3_count", {24'd0, frame_count_o}, 32'h3);
    check("f3_overrun", {31'd0, overrun_o}, 32'h0);
    cpu_read(5'd3, 32'h0);
    cpu_read(5'd4, 32'h44);

    // 5. empty CS pulse, then wrap the frame counter
    spi_cs_i = 1'b0;
    tick();
    spi_cs_i = 1'b1;
    tick();
    tick();
    check("empty_count", {24'd0, frame_count_o}, 32'h3);
    check("empty_wr_mask", wr_mask_o, 32'h10);
    check("empty_overrun", {31'd0, overrun_o}, 32'h0);
    for (int i = 0; i < 253; i++) begin
      spi_cs_i = 1'b0;
      tick();
      spi_write(5'd5, 32'h100 + 32'(i));
      spi_cs_i = 1'b1;
      tick();
      if (i == 251) check("count_255", {24'd0, frame_count_o}, 32'hFF);
    end
    check("wrap_count", {24'd0, frame_count_o}, 32'h0);
    check("wrap_wr_mask", wr_mask_o, 32'h20);
    check("wrap_overrun", {31'd0, overrun_o}, 32'h1);
    cpu_read(5'd5, 32'h1FC);

    // 6. reset in the middle of a frame
    spi_cs_i = 1'b0;
    tick();
    spi_write(5'd1, 32'h01010101);
    spi_write(5'd2, 32'h02020202);
    spi_write(5'd3, 32'h03030303);
    nrst = 1'b0;
    #1;
    check("mrst_wr_mask", wr_mask_o, 32'h0);
    check("mrst_ready", {31'd0, frame_ready_o}, 32'h0);
    check("mrst_count", {24'd0, frame_count_o}, 32'h0);
    tick();
    nrst = 1'b1;
    tick();
    spi_cs_i = 1'b1;
    tick();
    tick();
    check("post_wr_mask", wr_mask_o, 32'h0);
    check("post_ready", {31'd0, frame_ready_o}, 32'h0);
    check("post_count", {24'd0, frame_count_o}, 32'h0);
    cpu_read(5'd1, 32'h0);
    cpu_read(5'd2, 32'h0);

    // held request: 6 cycles give 3 acks
    acks_before = ack_count;
    push_exp(5'd2, 32'h0);
    push_exp(5'd2, 32'h0);
    push_exp(5'd2, 32'h0);
    cpu_addr_i   = 5'd2;
    cpu_rd_req_i = 1'b1;
    repeat (6) tick();
    cpu_rd_req_i = 1'b0;
    tick();
    tick();
    check("held_acks", 32'(ack_count - acks_before), 32'd3);
    check("pending_reads", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
